cfa_window_assembler: RTL and testbench

Receive-side partner of the CFA read-address generator: it accepts the pixel stream returned for each generated address, in column-major FILTER_SIZE-tall columns, and assembles a sliding FILTER_SIZE×FILTER_SIZE window. Out-of-frame addresses are padded with zero. One complete window is presented per column step on a valid/ready output to the demosaic datapath. Backpressure is returned to the address generator on `en`.

---
 rtl/cfa_window_assembler_pkg.sv | 24 ++
 rtl/cfa_window_assembler_column_stage.sv | 92 +++++++++
 rtl/cfa_window_assembler.sv | 244 ++++++++++++++++++++++++
 tb/tb_cfa_window_assembler.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cfa_window_assembler_pkg.sv
// Shared CFA window-assembler package.
// Holds the one-hot assembler state encoding, the default filter size and the
// window pixel index helper. Pixel (c, r) of a window or column lives at pixel
// slot c*FILTER_SIZE + r; column 0 is the leftmost, row 0 the top.
package cfa_window_assembler_pkg;

  localparam int unsigned CFA_FILTER_SIZE = 5;

  typedef enum logic [4:0] {
    CFA_WIN_IDLE   = 5'b00001,
    CFA_WIN_FILL   = 5'b00010,
    CFA_WIN_STREAM = 5'b00100,
    CFA_WIN_FLUSH  = 5'b01000,
    CFA_WIN_DONE   = 5'b10000
  } cfa_win_state_e;

  // Pixel slot of (c, r) inside a FILTER_SIZE x FILTER_SIZE window.
  function automatic int unsigned cfa_win_idx(input int unsigned c,
                                              input int unsigned r,
                                              input int unsigned fs);
    return c * fs + r;
  endfunction

endpackage

// File: rtl/cfa_window_assembler_column_stage.sv
// cfa_column_stage: staging column for the CFA window assembler.
// Collects FILTER_SIZE pixels of one column (top row first), zeroing padding
// positions, and flags col_full once the bottom row is written.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   clr             discard the partial column (frame start)
//   wr_en           write pix_data (or 0 when !pix_in_frame) at the write index
//   row_flush       this write starts a new row: write at index 0
//   commit          column consumed by the window array; clears col_full
//   col             staged column, row r at pixel slot r
//   col_full        whole column staged, awaiting commit
//   col_partial     (CFA_WIN_ERR_EN only) a column is partly written
module cfa_column_stage
  import cfa_window_assembler_pkg::*;
#(
  parameter int unsigned PIX_W       = 8,
  parameter int unsigned FILTER_SIZE = CFA_FILTER_SIZE
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clr,
  input  logic                         wr_en,
  input  logic                         row_flush,
  input  logic                         commit,
  input  logic [PIX_W-1:0]             pix_data,
  input  logic                         pix_in_frame,
  output logic [FILTER_SIZE*PIX_W-1:0] col,
  output logic                         col_full
`ifdef CFA_WIN_ERR_EN
  ,
  output logic                         col_partial
`endif
);

  localparam int unsigned IDX_W = $clog2(FILTER_SIZE);

  logic [FILTER_SIZE*PIX_W-1:0] col_q, col_d;
  logic [IDX_W-1:0]             wr_idx_q, wr_idx_d;
  logic                         col_full_q, col_full_d;
  logic [IDX_W-1:0]             wr_pos;

  always_comb begin
    col_d      = col_q;
    wr_idx_d   = wr_idx_q;
    col_full_d = col_full_q;
    wr_pos     = row_flush ? '0 : wr_idx_q;
    if (clr) begin
      col_d      = '0;
      wr_idx_d   = '0;
      col_full_d = 1'b0;
    end else begin
      if (commit) begin
        col_full_d = 1'b0;
        wr_idx_d   = '0;
      end
      if (wr_en) begin
        for (int unsigned r = 0; r < FILTER_SIZE; r++) begin
          if (IDX_W'(r) == wr_pos) begin
            col_d[cfa_win_idx(0, r, FILTER_SIZE)*PIX_W +: PIX_W] =
              pix_in_frame ? pix_data : '0;
          end
        end
        // Index wraps to 0 on the bottom row so a committed column starts clean.
        if (wr_pos == IDX_W'(FILTER_SIZE - 1)) begin
          wr_idx_d   = '0;
          col_full_d = 1'b1;
        end else begin
          wr_idx_d = wr_pos + IDX_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      col_q      <= '0;
      wr_idx_q   <= '0;
      col_full_q <= 1'b0;
    end else begin
      col_q      <= col_d;
      wr_idx_q   <= wr_idx_d;
      col_full_q <= col_full_d;
    end
  end

  assign col      = col_q;
  assign col_full = col_full_q;
`ifdef CFA_WIN_ERR_EN
  assign col_partial = (wr_idx_q != '0);
`endif

endmodule

// File: rtl/cfa_window_assembler.sv
// cfa_window_assembler: assembles a sliding FILTER_SIZE x FILTER_SIZE window
// from the column-major pixel stream returned for the CFA address generator.
// Pipeline: staging column -> window shift array -> output register.
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   start                        begin frame (IDLE -> FILL, DONE -> IDLE)
//   pix_valid/pix_data           incoming pixel
//   pix_in_frame                 0 = padding position, stored as 0
//   row_update                   pixel is first of a new output row
//   frame_last                   current column is the last of the frame
//   en                           upstream may begin another column
//   win_valid/win_ready          output window handshake
//   window                       pixel (c, r) at [(c*FILTER_SIZE+r)*PIX_W +: PIX_W]
//   win_row/win_col              coordinates of the presented window
//   done                         frame complete, held until start
//   err                          only with CFA_WIN_ERR_EN: sticky protocol error
// Build option: define CFA_WIN_ERR_EN to add the err output.
module cfa_window_assembler
  import cfa_window_assembler_pkg::*;
#(
  parameter int unsigned PIX_W       = 8,
  parameter int unsigned FILTER_SIZE = CFA_FILTER_SIZE,
  parameter int unsigned ROW_W       = 11,
  parameter int unsigned COL_W       = 11
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic                                     start,
  input  logic                                     pix_valid,
  input  logic [PIX_W-1:0]                         pix_data,
  input  logic                                     pix_in_frame,
  input  logic                                     row_update,
  input  logic                                     frame_last,
  output logic                                     en,
  output logic                                     win_valid,
  input  logic                                     win_ready,
  output logic [FILTER_SIZE*FILTER_SIZE*PIX_W-1:0] window,
  output logic [ROW_W-1:0]                         win_row,
  output logic [COL_W-1:0]                         win_col,
  output logic                                     done
`ifdef CFA_WIN_ERR_EN
  ,
  output logic                                     err
`endif
);

  localparam int unsigned CNT_W    = $clog2(FILTER_SIZE + 1);
  localparam int unsigned COL_BITS = FILTER_SIZE * PIX_W;
  localparam int unsigned WIN_BITS = FILTER_SIZE * COL_BITS;

  cfa_win_state_e        state_q, state_d;
  logic [CNT_W-1:0]      fill_cnt_q, fill_cnt_d;
  logic [ROW_W-1:0]      row_cnt_q, row_cnt_d;
  logic [COL_W-1:0]      col_cnt_q, col_cnt_d;
  logic [WIN_BITS-1:0]   arr_q, arr_d;
  logic                  win_valid_q, win_valid_d;
  logic [WIN_BITS-1:0]   window_q, window_d;
  logic [ROW_W-1:0]      win_row_q, win_row_d;
  logic [COL_W-1:0]      win_col_q, win_col_d;
  logic                  done_q, done_d;
  logic                  row_pend_q, row_pend_d;
`ifdef CFA_WIN_ERR_EN
  logic                  err_q, err_d;
  logic                  col_partial;
`endif

  logic                  active, drop, wr_en, row_flush;
  logic                  emit_zone, out_busy, commit, emit, stage_clr;
  logic                  col_full;
  logic [COL_BITS-1:0]   stage_col;
  logic [WIN_BITS-1:0]   shifted;

  cfa_column_stage #(
    .PIX_W       (PIX_W),
    .FILTER_SIZE (FILTER_SIZE)
  ) u_stage (
    .clk          (clk),
    .rst          (rst),
    .clr          (stage_clr),
    .wr_en        (wr_en),
    .row_flush    (row_flush),
    .commit       (commit),
    .pix_data     (pix_data),
    .pix_in_frame (pix_in_frame),
    .col          (stage_col),
    .col_full     (col_full)
`ifdef CFA_WIN_ERR_EN
    ,
    .col_partial  (col_partial)
`endif
  );

  always_comb begin
    active = (state_q == CFA_WIN_FILL) || (state_q == CFA_WIN_STREAM);
`ifdef CFA_WIN_ERR_EN
    drop = pix_valid && row_update && col_partial;
`else
    drop = 1'b0;
`endif
    wr_en = active && pix_valid && !col_full && !drop;
    // A row_update that arrived while a full column was stalled is held in
    // row_pend_q and applied to the next accepted pixel, after the commit.
    row_flush = wr_en && (row_update || row_pend_q);
    emit_zone = fill_cnt_q >= CNT_W'(FILTER_SIZE - 1);
    out_busy  = win_valid_q && !win_ready;
    commit    = active && col_full && !(emit_zone && out_busy);
    emit      = commit && emit_zone;
    shifted   = {stage_col, arr_q[WIN_BITS-1:COL_BITS]};
    en        = !col_full && !out_busy;
  end

  always_comb begin
    state_d     = state_q;
    fill_cnt_d  = fill_cnt_q;
    row_cnt_d   = row_cnt_q;
    col_cnt_d   = col_cnt_q;
    arr_d       = arr_q;
    win_valid_d = win_valid_q;
    window_d    = window_q;
    win_row_d   = win_row_q;
    win_col_d   = win_col_q;
    done_d      = done_q;
    row_pend_d  = row_pend_q;
    stage_clr   = 1'b0;
`ifdef CFA_WIN_ERR_EN
    err_d = err_q;
    if (active && pix_valid && (col_full || (row_update && col_partial)))
      err_d = 1'b1;
`endif

    if (win_valid_q && win_ready) win_valid_d = 1'b0;

    if (commit) begin
      arr_d      = shifted;
      fill_cnt_d = emit_zone ? CNT_W'(FILTER_SIZE) : fill_cnt_q + CNT_W'(1);
    end

    // Loading the output register in the accept cycle gives bubble-free reuse.
    if (emit) begin
      win_valid_d = 1'b1;
      window_d    = shifted;
      win_row_d   = row_cnt_q;
      win_col_d   = col_cnt_q;
      col_cnt_d   = col_cnt_q + COL_W'(1);
    end

    if (row_flush) begin
      fill_cnt_d = '0;
      col_cnt_d  = '0;
      row_cnt_d  = row_cnt_q + ROW_W'(1);
      row_pend_d = 1'b0;
    end

    if (active && pix_valid && row_update && col_full) row_pend_d = 1'b1;

    case (state_q)
      CFA_WIN_IDLE: begin
        if (start) begin
          state_d    = CFA_WIN_FILL;
          fill_cnt_d = '0;
          row_cnt_d  = '0;
          col_cnt_d  = '0;
          row_pend_d = 1'b0;
          win_row_d  = '0;
          win_col_d  = '0;
          stage_clr  = 1'b1;
`ifdef CFA_WIN_ERR_EN
          err_d = 1'b0;
`endif
        end
      end
      CFA_WIN_FILL: begin
        if (commit && frame_last) state_d = CFA_WIN_FLUSH;
        else if (emit)            state_d = CFA_WIN_STREAM;
      end
      CFA_WIN_STREAM: begin
        if (commit && frame_last) state_d = CFA_WIN_FLUSH;
        else if (row_flush)       state_d = CFA_WIN_FILL;
      end
      CFA_WIN_FLUSH: begin
        if (!win_valid_q) begin
          state_d = CFA_WIN_DONE;
          done_d  = 1'b1;
        end
      end
      CFA_WIN_DONE: begin
        if (start) begin
          state_d   = CFA_WIN_IDLE;
          done_d    = 1'b0;
          row_cnt_d = '0;
          win_row_d = '0;
`ifdef CFA_WIN_ERR_EN
          err_d = 1'b0;
`endif
        end
      end
      default: state_d = CFA_WIN_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= CFA_WIN_IDLE;
      fill_cnt_q  <= '0;
      row_cnt_q   <= '0;
      col_cnt_q   <= '0;
      arr_q       <= '0;
      win_valid_q <= 1'b0;
      window_q    <= '0;
      win_row_q   <= '0;
      win_col_q   <= '0;
      done_q      <= 1'b0;
      row_pend_q  <= 1'b0;
`ifdef CFA_WIN_ERR_EN
      err_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      fill_cnt_q  <= fill_cnt_d;
      row_cnt_q   <= row_cnt_d;
      col_cnt_q   <= col_cnt_d;
      arr_q       <= arr_d;
      win_valid_q <= win_valid_d;
      window_q    <= window_d;
      win_row_q   <= win_row_d;
      win_col_q   <= win_col_d;
      done_q      <= done_d;
      row_pend_q  <= row_pend_d;
`ifdef CFA_WIN_ERR_EN
      err_q       <= err_d;
`endif
    end
  end

  assign win_valid = win_valid_q;
  assign window    = window_q;
  assign win_row   = win_row_q;
  assign win_col   = win_col_q;
  assign done      = done_q;
`ifdef CFA_WIN_ERR_EN
  assign err = err_q;
`endif

endmodule

// File: tb/tb_cfa_window_assembler.sv
// Directed testbench for cfa_window_assembler (FILTER_SIZE=5, PIX_W=8).
module tb_cfa_window_assembler;

  localparam int FS = 5;
  localparam int PW = 8;
  localparam int WB = FS * FS * PW;

  logic          clk;
  logic          rst;
  logic          start;
  logic          pix_valid;
  logic [PW-1:0] pix_data;
  logic          pix_in_frame;
  logic          row_update;
  logic          frame_last;
  logic          en;
  logic          win_valid;
  logic          win_ready;
  logic [WB-1:0] window;
  logic [10:0]   win_row;
  logic [10:0]   win_col;
  logic          done;
`ifdef CFA_WIN_ERR_EN
  logic          err;
`endif

  int checks = 0;
  int passed = 0;

  cfa_window_assembler #(
    .PIX_W       (PW),
    .FILTER_SIZE (FS),
    .ROW_W       (11),
    .COL_W       (11)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .pix_valid    (pix_valid),
    .pix_data     (pix_data),
    .pix_in_frame (pix_in_frame),
    .row_update   (row_update),
    .frame_last   (frame_last),
    .en           (en),
    .win_valid    (win_valid),
    .win_ready    (win_ready),
    .window       (window),
    .win_row      (win_row),
    .win_col      (win_col),
    .done         (done)
`ifdef CFA_WIN_ERR_EN
    ,
    .err          (err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, got running want finished");
    $fatal(1, "timeout");
  end

  // Expected window whose (c, r) pixel is first + c*FS + r.
  function automatic logic [WB-1:0] mk_win(input int first);
    logic [WB-1:0] w;
    w = '0;
    for (int c = 0; c < FS; c++)
      for (int r = 0; r < FS; r++)
        w[(c*FS + r)*PW +: PW] = 8'(first + c*FS + r);
    return w;
  endfunction

  function automatic logic [PW-1:0] px(input logic [WB-1:0] w, input int c, input int r);
    return w[(c*FS + r)*PW +: PW];
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // One column, rows top to bottom, values first..first+4.
  task automatic send_col(input int first, input logic [FS-1:0] pad,
                          input logic rowu, input logic last);
    for (int r = 0; r < FS; r++) begin
      pix_valid    = 1'b1;
      pix_data     = 8'(first + r);
      pix_in_frame = !pad[r];
      row_update   = (r == 0) && rowu;
      frame_last   = last;
      cyc();
    end
    pix_valid    = 1'b0;
    row_update   = 1'b0;
    pix_in_frame = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cyc();
    cyc();
    checks++; if (win_valid !== 1'b0) $display("FAIL rst_win_valid: got %0b want 0", win_valid); else passed++;
    checks++; if (done !== 1'b0) $display("FAIL rst_done: got %0b want 0", done); else passed++;
    checks++; if (window !== '0) $display("FAIL rst_window: got %h want 0", window); else passed++;
    checks++; if (win_row !== 11'd0) $display("FAIL rst_win_row: got %0d want 0", win_row); else passed++;
    checks++; if (win_col !== 11'd0) $display("FAIL rst_win_col: got %0d want 0", win_col); else passed++;
    checks++; if (en !== 1'b1) $display("FAIL rst_en: got %0b want 1", en); else passed++;
`ifdef CFA_WIN_ERR_EN
    checks++; if (err !== 1'b0) $display("FAIL rst_err: got %0b want 0", err); else passed++;
`endif
    rst = 1'b0;
    cyc();
  endtask

  task automatic test_basic();
    start = 1'b1;
    cyc();
    start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      send_col(k*FS + 1, '0, 1'b0, 1'b0);
      cyc();
      checks++; if (win_valid !== 1'b0) $display("FAIL basic_fill_k%0d: win_valid got %0b want 0", k, win_valid); else passed++;
    end
    send_col(21, '0, 1'b0, 1'b0);
    checks++; if (win_valid !== 1'b0) $display("FAIL basic_latency1: win_valid got %0b want 0", win_valid); else passed++;
    cyc();
    checks++; if (win_valid !== 1'b1) $display("FAIL basic_latency2: win_valid got %0b want 1", win_valid); else passed++;
    checks++; if (px(window, 0, 0) !== 8'd1) $display("FAIL basic_p00: got %0d want 1", px(window, 0, 0)); else passed++;
    checks++; if (px(window, 4, 4) !== 8'd25) $display("FAIL basic_p44: got %0d want 25", px(window, 4, 4)); else passed++;
    checks++; if (window !== mk_win(1)) $display("FAIL basic_window: got %h want %h", window, mk_win(1)); else passed++;
    checks++; if (win_row !== 11'd0) $display("FAIL basic_row: got %0d want 0", win_row); else passed++;
    checks++; if (win_col !== 11'd0) $display("FAIL basic_col: got %0d want 0", win_col); else passed++;
  endtask

  task automatic test_backpressure();
    send_col(26, '0, 1'b0, 1'b0);
    checks++; if (en !== 1'b0) $display("FAIL bp_en_full: got %0b want 0", en); else passed++;
    cyc();
    checks++; if (en !== 1'b0) $display("FAIL bp_en_stall: got %0b want 0", en); else passed++;
    checks++; if (window !== mk_win(1)) $display("FAIL bp_window_hold: got %h want %h", window, mk_win(1)); else passed++;
    checks++; if (win_col !== 11'd0) $display("FAIL bp_col_hold: got %0d want 0", win_col); else passed++;
    win_ready = 1'b1;
    cyc();
    checks++; if (win_valid !== 1'b1) $display("FAIL bp_release_valid: got %0b want 1", win_valid); else passed++;
    checks++; if (win_col !== 11'd1) $display("FAIL bp_release_col: got %0d want 1", win_col); else passed++;
    checks++; if (window !== mk_win(6)) $display("FAIL bp_release_window: got %h want %h", window, mk_win(6)); else passed++;
    checks++; if (en !== 1'b1) $display("FAIL bp_release_en: got %0b want 1", en); else passed++;
  endtask

  task automatic test_back_to_back();
    for (int k = 6; k <= 10; k++) begin
      send_col(k*FS + 1, '0, 1'b0, 1'b0);
      cyc();
      checks++; if (win_valid !== 1'b1) $display("FAIL stream_valid_k%0d: got %0b want 1", k, win_valid); else passed++;
      checks++; if (win_col !== 11'(k - 4)) $display("FAIL stream_col_k%0d: got %0d want %0d", k, win_col, k - 4); else passed++;
      checks++; if (window !== mk_win((k - 4)*FS + 1)) $display("FAIL stream_window_k%0d: got %h want %h", k, window, mk_win((k - 4)*FS + 1)); else passed++;
    end
    cyc();
    checks++; if (win_valid !== 1'b0) $display("FAIL stream_drain: win_valid got %0b want 0", win_valid); else passed++;
  endtask

  task automatic test_row_change();
    for (int j = 0; j < FS; j++) begin
      send_col(100 + j*FS, '0, (j == 0), 1'b0);
      cyc();
      if (j < FS - 1) begin
        checks++; if (win_valid !== 1'b0) $display("FAIL row_refill_j%0d: win_valid got %0b want 0", j, win_valid); else passed++;
      end
    end
    checks++; if (win_valid !== 1'b1) $display("FAIL row_valid: got %0b want 1", win_valid); else passed++;
    checks++; if (win_row !== 11'd1) $display("FAIL row_row: got %0d want 1", win_row); else passed++;
    checks++; if (win_col !== 11'd0) $display("FAIL row_col: got %0d want 0", win_col); else passed++;
    checks++; if (window !== mk_win(100)) $display("FAIL row_window: got %h want %h", window, mk_win(100)); else passed++;
    cyc();
  endtask

  task automatic test_padding();
    logic [WB-1:0] exp_w;
    for (int j = 0; j < FS; j++) begin
      send_col(150 + j*FS, (j == 0) ? 5'b00011 : 5'b00000, (j == 0), 1'b0);
      cyc();
    end
    exp_w = mk_win(150);
    exp_w[2*PW-1:0] = '0;
    checks++; if (win_valid !== 1'b1) $display("FAIL pad_valid: got %0b want 1", win_valid); else passed++;
    checks++; if (win_row !== 11'd2) $display("FAIL pad_row: got %0d want 2", win_row); else passed++;
    checks++; if (px(window, 0, 0) !== 8'd0) $display("FAIL pad_p00: got %0d want 0", px(window, 0, 0)); else passed++;
    checks++; if (px(window, 0, 1) !== 8'd0) $display("FAIL pad_p01: got %0d want 0", px(window, 0, 1)); else passed++;
    checks++; if (px(window, 0, 2) !== 8'd152) $display("FAIL pad_p02: got %0d want 152", px(window, 0, 2)); else passed++;
    checks++; if (window !== exp_w) $display("FAIL pad_window: got %h want %h", window, exp_w); else passed++;
    cyc();
  endtask

  task automatic test_frame_end();
    win_ready = 1'b0;
    send_col(175, '0, 1'b0, 1'b1);
    cyc();
    frame_last = 1'b0;
    checks++; if (win_valid !== 1'b1) $display("FAIL end_valid: got %0b want 1", win_valid); else passed++;
    checks++; if (win_col !== 11'd1) $display("FAIL end_col: got %0d want 1", win_col); else passed++;
    checks++; if (window !== mk_win(155)) $display("FAIL end_window: got %h want %h", window, mk_win(155)); else passed++;
    cyc();
    checks++; if (done !== 1'b0) $display("FAIL end_done_early: got %0b want 0", done); else passed++;
    win_ready = 1'b1;
    cyc();
    checks++; if (win_valid !== 1'b0) $display("FAIL end_accepted: win_valid got %0b want 0", win_valid); else passed++;
    checks++; if (done !== 1'b0) $display("FAIL end_done_accept_cycle: got %0b want 0", done); else passed++;
    win_ready = 1'b0;
    cyc();
    checks++; if (done !== 1'b1) $display("FAIL end_done_rise: got %0b want 1", done); else passed++;
    send_col(1, '0, 1'b0, 1'b0);
    cyc();
    checks++; if (done !== 1'b1) $display("FAIL end_done_hold: got %0b want 1", done); else passed++;
    checks++; if (win_valid !== 1'b0) $display("FAIL end_drop_in_done: win_valid got %0b want 0", win_valid); else passed++;
    start = 1'b1;
    cyc();
    start = 1'b0;
    checks++; if (done !== 1'b0) $display("FAIL end_done_clear: got %0b want 0", done); else passed++;
    checks++; if (win_row !== 11'd0) $display("FAIL end_row_clear: got %0d want 0", win_row); else passed++;
  endtask

  task automatic test_mid_reset();
    start = 1'b1;
    cyc();
    start = 1'b0;
    for (int k = 0; k < FS; k++) begin
      send_col(k*FS + 1, '0, 1'b0, 1'b0);
      cyc();
    end
    for (int r = 0; r < 3; r++) begin
      pix_valid = 1'b1;
      pix_data  = 8'(200 + r);
      cyc();
    end
    pix_valid = 1'b0;
    rst = 1'b1;
    cyc();
    checks++; if (win_valid !== 1'b0) $display("FAIL mrst_win_valid: got %0b want 0", win_valid); else passed++;
    checks++; if (window !== '0) $display("FAIL mrst_window: got %h want 0", window); else passed++;
    checks++; if (win_col !== 11'd0) $display("FAIL mrst_win_col: got %0d want 0", win_col); else passed++;
    checks++; if (en !== 1'b1) $display("FAIL mrst_en: got %0b want 1", en); else passed++;
    checks++; if (done !== 1'b0) $display("FAIL mrst_done: got %0b want 0", done); else passed++;
    rst = 1'b0;
    start = 1'b1;
    cyc();
    start = 1'b0;
    for (int k = 0; k < FS; k++) begin
      send_col(31 + k*FS, '0, 1'b0, 1'b0);
      cyc();
    end
    checks++; if (win_valid !== 1'b1) $display("FAIL mrst_refill_valid: got %0b want 1", win_valid); else passed++;
    checks++; if (window !== mk_win(31)) $display("FAIL mrst_refill_window: got %h want %h", window, mk_win(31)); else passed++;
  endtask

`ifdef CFA_WIN_ERR_EN
  task automatic test_err();
    send_col(56, '0, 1'b0, 1'b0);
    checks++; if (err !== 1'b0) $display("FAIL err_clean: got %0b want 0", err); else passed++;
    pix_valid = 1'b1;
    pix_data  = 8'd99;
    cyc();
    pix_valid = 1'b0;
    checks++; if (err !== 1'b1) $display("FAIL err_overflow: got %0b want 1", err); else passed++;
    checks++; if (window !== mk_win(31)) $display("FAIL err_window_hold: got %h want %h", window, mk_win(31)); else passed++;
  endtask
`endif

  initial begin
    rst          = 1'b1;
    start        = 1'b0;
    pix_valid    = 1'b0;
    pix_data     = '0;
    pix_in_frame = 1'b1;
    row_update   = 1'b0;
    frame_last   = 1'b0;
    win_ready    = 1'b0;
    test_reset();
    test_basic();
    test_backpressure();
    test_back_to_back();
    test_row_change();
    test_padding();
    test_frame_end();
    test_mid_reset();
`ifdef CFA_WIN_ERR_EN
    test_err();
`endif
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
